// File: rtl/zigzag_rle_pkg.sv
// zigzag_rle shared types: widths, FSM states, symbol bundle
// and the 8x8 zigzag scan table.
package zigzag_rle_pkg;

  localparam int COEF_W = 12;
  localparam int SIZE_W = 4;
  localparam int RUN_W  = 4;

  typedef enum logic [2:0] {
    IDLE, ADDR, EVAL, ZRL, EMIT, EOB, DONE
  } state_t;

  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [SIZE_W-1:0] size;
    logic [COEF_W-1:0] amp;
    logic              dc;
  } sym_t;

  // raster position of each zigzag index
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [COEF_W-1:0] sat_coef(
    input logic [COEF_W-1:0] raw
  );
    return (raw == 12'h800) ? 12'h801 : raw;
  endfunction

endpackage

// File: rtl/zigzag_rle_if.sv
// zigzag_rle symbol stream towards the Huffman stage.
// Valid/ready; fields hold while valid && !ready.
interface zigzag_rle_if;
  import zigzag_rle_pkg::*;

  logic              sym_valid;
  logic              sym_ready;
  logic [RUN_W-1:0]  sym_run;
  logic [SIZE_W-1:0] sym_size;
  logic [COEF_W-1:0] sym_amp;
  logic              sym_dc;

  modport master (
    output sym_valid, sym_run, sym_size,
    output sym_amp, sym_dc,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_run, sym_size,
    input  sym_amp, sym_dc,
    output sym_ready
  );

endinterface

// File: rtl/zz_size_amp.sv
// zz_size_amp: JPEG magnitude category and amplitude bits
// of a 13-bit signed value (DC difference or AC coefficient).
module zz_size_amp
  import zigzag_rle_pkg::*;
(
  input  logic signed [COEF_W:0] x,
  output logic [SIZE_W-1:0]      size,
  output logic [COEF_W-1:0]      amp
);

  logic [COEF_W-1:0] mag;
  logic [COEF_W-1:0] xm1;
  logic [COEF_W-1:0] mask;

  always_comb begin
    mag = x[COEF_W] ? COEF_W'(-x) : x[COEF_W-1:0];
    size = '0;
    for (int i = 0; i < COEF_W; i++)
      if (mag[i]) size = SIZE_W'(i + 1);
    xm1  = x[COEF_W-1:0] - 12'd1;
    mask = 12'hFFF >> (4'd12 - size);
    amp  = x[COEF_W] ? (xm1 & mask) : x[COEF_W-1:0];
  end

endmodule

// File: rtl/zigzag_rle.sv
// zigzag_rle: zigzag readback + JPEG run-length symbol coder.
// Define ZIGZAG_RLE_DC_PRED_EN for differential DC coding.
module zigzag_rle
  import zigzag_rle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  blk_sel,
  input  logic        dc_clr,
  output logic        done,
  output logic        busy,
  output logic [7:0]  rd_addr,
  input  logic [31:0] rd_data,
  zigzag_rle_if.master sym
);

  state_t            st;
  logic [1:0]        blk_q;
  logic [5:0]        k;
  logic [5:0]        run;
  logic [5:0]        run_z;
  logic [SIZE_W-1:0] p_size;
  logic [COEF_W-1:0] p_amp;
  sym_t              sq;
  logic              vld;
  logic              acc;
  logic signed [COEF_W-1:0] v;
  logic signed [COEF_W:0]   x;
  logic [SIZE_W-1:0] x_size;
  logic [COEF_W-1:0] x_amp;
  logic              unused_bits;

`ifdef ZIGZAG_RLE_DC_PRED_EN
  logic signed [COEF_W-1:0] pred;
  assign unused_bits = ^rd_data[31:COEF_W];
`else
  assign unused_bits = ^{rd_data[31:COEF_W], dc_clr};
`endif

  assign v     = sat_coef(rd_data[COEF_W-1:0]);
  assign acc   = vld & sym.sym_ready;
  assign run_z = run - 6'd16;

  always_comb begin
    x = {v[COEF_W-1], v};
`ifdef ZIGZAG_RLE_DC_PRED_EN
    if (k == 6'd0)
      x = {v[COEF_W-1], v} - {pred[COEF_W-1], pred};
`endif
  end

  zz_size_amp u_sa (
    .x    (x),
    .size (x_size),
    .amp  (x_amp)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= IDLE;
      blk_q   <= '0;
      k       <= '0;
      run     <= '0;
      p_size  <= '0;
      p_amp   <= '0;
      sq      <= '0;
      vld     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      rd_addr <= '0;
`ifdef ZIGZAG_RLE_DC_PRED_EN
      pred    <= '0;
`endif
    end else begin
      unique case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            blk_q   <= blk_sel;
            k       <= '0;
            run     <= '0;
            busy    <= 1'b1;
            rd_addr <= {blk_sel, ZZ[0]};
            st      <= ADDR;
`ifdef ZIGZAG_RLE_DC_PRED_EN
            if (dc_clr) pred <= '0;
`endif
          end
        end
        ADDR: st <= EVAL;
        EVAL: begin
          if (k == 6'd0) begin
`ifdef ZIGZAG_RLE_DC_PRED_EN
            pred <= v;
`endif
            sq  <= '{4'd0, x_size, x_amp, 1'b1};
            vld <= 1'b1;
            st  <= EMIT;
          end else if (v == '0) begin
            run <= run + 6'd1;
            if (k == 6'd63) begin
              sq  <= '0;
              vld <= 1'b1;
              st  <= EOB;
            end else begin
              k       <= k + 6'd1;
              rd_addr <= {blk_q, ZZ[k + 6'd1]};
              st      <= ADDR;
            end
          end else begin
            p_size <= x_size;
            p_amp  <= x_amp;
            vld    <= 1'b1;
            if (run >= 6'd16) begin
              sq <= '{4'd15, 4'd0, 12'd0, 1'b0};
              st <= ZRL;
            end else begin
              sq <= '{run[3:0], x_size, x_amp, 1'b0};
              st <= EMIT;
            end
          end
        end
        ZRL: begin
          if (acc) begin
            run <= run_z;
            // stay in ZRL with the same symbol while a full 16-run remains
            if (run_z < 6'd16) begin
              sq <= '{run_z[3:0], p_size, p_amp, 1'b0};
              st <= EMIT;
            end
          end
        end
        EMIT: begin
          if (acc) begin
            run <= '0;
            vld <= 1'b0;
            if (k == 6'd63) begin
              done <= 1'b1;
              busy <= 1'b0;
              st   <= DONE;
            end else begin
              k       <= k + 6'd1;
              rd_addr <= {blk_q, ZZ[k + 6'd1]};
              st      <= ADDR;
            end
          end
        end
        EOB: begin
          if (acc) begin
            vld  <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            st   <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign sym.sym_valid = vld;
  assign sym.sym_run   = sq.run;
  assign sym.sym_size  = sq.size;
  assign sym.sym_amp   = sq.amp;
  assign sym.sym_dc    = sq.dc;

endmodule

// File: tb/tb_zigzag_rle.sv
// Bench for zigzag_rle: directed blocks, queue model of the
// zigzag/RLE rules and a per-cycle symbol monitor.
module tb_zigzag_rle;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        dc;
  } es_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dc_clr;
  logic        done;
  logic        busy;
  logic [1:0]  blk_sel;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] mem [256];
  logic [31:0] blk [64];
  int          zz_tab [64];
  es_t         exp_q [$];
  es_t         got_q [$];
  es_t         prev;
  bit          hold;
  int          mpred;
  int          total;
  int          bad;
  int          lat;
  int          n;

  zigzag_rle_if sif();

  zigzag_rle dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .blk_sel (blk_sel),
    .dc_clr  (dc_clr),
    .done    (done),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .sym     (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lit(input int r, input int s,
                                      input int a, input int d);
    return {11'd0, 4'(r), 4'(s), 12'(a), 1'(d)};
  endfunction

  function automatic logic [31:0] gq(input int i);
    return (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
  endfunction

  // walk the anti-diagonals, alternating direction
  task automatic build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++)
      for (int j = 0; j < 8; j++) begin
        int r;
        int c;
        r = (s % 2 == 0) ? ((s < 8 ? s : 7) - j)
                         : ((s < 8 ? 0 : s - 7) + j);
        c = s - r;
        if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
          zz_tab[idx] = r * 8 + c;
          idx++;
        end
      end
  endtask

  function automatic es_t mk(input int run, input int x, input bit dc);
    es_t s;
    int  mag;
    int  sz;
    mag = (x < 0) ? -x : x;
    sz = 0;
    while ((1 << sz) <= mag) sz++;
    s.run  = 4'(run);
    s.size = 4'(sz);
    s.amp  = 12'((x >= 0) ? x : x + (1 << sz) - 1);
    s.dc   = dc;
    return s;
  endfunction

  task automatic clear_blk();
    for (int p = 0; p < 64; p++) blk[p] = 32'd0;
  endtask

  task automatic load(input logic [1:0] slot, input bit dcc);
    int c [64];
    int run;
    int last;
    int d;
    for (int p = 0; p < 64; p++) mem[{slot, 6'(p)}] = blk[p];
    for (int i = 0; i < 64; i++) begin
      c[i] = int'($signed(blk[zz_tab[i]][11:0]));
      if (c[i] == -2048) c[i] = -2047;
    end
    if (dcc) mpred = 0;
`ifdef ZIGZAG_RLE_DC_PRED_EN
    d = c[0] - mpred;
`else
    d = c[0];
`endif
    mpred = c[0];
    exp_q.push_back(mk(0, d, 1'b1));
    last = 0;
    for (int i = 1; i < 64; i++) if (c[i] != 0) last = i;
    run = 0;
    for (int i = 1; i <= last; i++) begin
      if (c[i] == 0) run++;
      else begin
        while (run >= 16) begin
          exp_q.push_back(mk(15, 0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(run, c[i], 1'b0));
        run = 0;
      end
    end
    if (last < 63) exp_q.push_back(mk(0, 0, 1'b0));
  endtask

  always @(negedge clk) begin
    es_t cur;
    es_t e;
    cur = {sif.sym_run, sif.sym_size, sif.sym_amp, sif.sym_dc};
    if (!rst) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold)
        chk("stall_hold", {11'd0, sif.sym_valid, cur[19:0]},
            {11'd0, 1'b1, prev[19:0]});
      if (sif.sym_valid && sif.sym_ready) begin
        got_q.push_back(cur);
        chk("sym_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sym", 32'(cur), 32'(e));
        end
      end
      hold = sif.sym_valid && !sif.sym_ready;
      prev = cur;
    end
  end

  task automatic run_block(input logic [1:0] slot, input bit dcc,
                           input bit poke, output int l);
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1; blk_sel = slot; dc_clr = dcc;
    @(posedge clk); #1;
    start = 1'b0; blk_sel = ~slot; dc_clr = ~dcc;
    @(negedge clk);
    l = 1;
    chk("addr0", {24'd0, rd_addr}, {24'd0, slot, 6'd0});
    chk("busy", 32'(busy), 32'd1);
    while (!done && l < 400) begin
      @(negedge clk);
      l++;
      start = poke && (l == 5);
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(sif.sym_valid), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_fields"},
        32'({sif.sym_run, sif.sym_size, sif.sym_amp, sif.sym_dc}), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; mpred = 0; hold = 1'b0;
    rst = 1'b0; start = 1'b0; blk_sel = 2'd0; dc_clr = 1'b0;
    sif.sym_ready = 1'b1;
    build_zz();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("zz21", 32'(zz_tab[21]), 32'd48);
    chk_reset("rst");
    @(posedge clk); #1 rst = 1'b1;

    // all-zero block
    clear_blk(); load(2'd0, 1'b1);
    run_block(2'd0, 1'b1, 1'b0, lat);
    chk("lat_zero", 32'(lat), 32'd131);
    chk("a_n", 32'(got_q.size()), 32'd2);
    chk("a_dc", gq(0), lit(0, 0, 0, 1));
    chk("a_eob", gq(1), lit(0, 0, 0, 0));

    // DC 5 then DC 3, predictor kept
    clear_blk(); blk[0] = 32'd5; load(2'd1, 1'b1);
    run_block(2'd1, 1'b1, 1'b0, lat);
    chk("b_dc5", gq(0), lit(0, 3, 5, 1));
    clear_blk(); blk[0] = 32'd3; load(2'd2, 1'b0);
    run_block(2'd2, 1'b0, 1'b1, lat);
`ifdef ZIGZAG_RLE_DC_PRED_EN
    chk("b_dc3", gq(0), lit(0, 2, 1, 1));
`else
    chk("b_dc3", gq(0), lit(0, 2, 3, 1));
`endif

    // zigzag index 21 = -3
    clear_blk(); blk[48] = 32'h0000_0FFD; load(2'd3, 1'b1);
    run_block(2'd3, 1'b1, 1'b0, lat);
    chk("c_n", 32'(got_q.size()), 32'd4);
    chk("c_zrl", gq(1), lit(15, 0, 0, 0));
    chk("c_sym", gq(2), lit(4, 2, 0, 0));
    chk("c_eob", gq(3), lit(0, 0, 0, 0));

    // only coefficient 63 = 1
    clear_blk(); blk[63] = 32'd1; load(2'd0, 1'b1);
    run_block(2'd0, 1'b1, 1'b1, lat);
    chk("d_n", 32'(got_q.size()), 32'd5);
    chk("d_zrl3", gq(3), lit(15, 0, 0, 0));
    chk("d_last", gq(4), lit(14, 1, 1, 0));

    // -2048 saturation, upper word bits ignored
    for (int p = 0; p < 64; p++) blk[p] = 32'hFFFF_F000;
    blk[0] = 32'h0000_0800; blk[1] = 32'h0000_0800;
    load(2'd1, 1'b1);
    run_block(2'd1, 1'b1, 1'b0, lat);
    chk("e_n", 32'(got_q.size()), 32'd3);
    chk("e_dc", gq(0), lit(0, 11, 0, 1));
    chk("e_ac", gq(1), lit(0, 11, 0, 0));

    // fully nonzero block
    for (int p = 0; p < 64; p++) begin
      int v;
      v = ((p * 37 + 11) % 200) - 100;
      if (v == 0) v = 7;
      blk[p] = 32'(v);
    end
    load(2'd2, 1'b0);
    run_block(2'd2, 1'b0, 1'b0, lat);
    chk("lat_full", 32'(lat), 32'd193);
    chk("f_n", 32'(got_q.size()), 32'd64);

    // stall on the DC symbol, then reset mid-block
    clear_blk();
    blk[0] = 32'd100; blk[1] = 32'd5; blk[8] = 32'hFFFF_FFFA; blk[9] = 32'd1;
    load(2'd1, 1'b1);
    got_q.delete();
    sif.sym_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; blk_sel = 2'd1; dc_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!sif.sym_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_valid", 32'(sif.sym_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("s_noacc", 32'(got_q.size()), 32'd0);
    @(posedge clk); #1 sif.sym_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_reset("mid");
    mpred = 0;
    clear_blk(); blk[0] = 32'd9; load(2'd2, 1'b0);
    run_block(2'd2, 1'b0, 1'b0, lat);
    chk("g_n", 32'(got_q.size()), 32'd2);
    chk("g_dc", gq(0), lit(0, 4, 9, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
